// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with wrap/saturate, terminal-count pulse and sticky flags
module param_counter #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             zero
);
  logic             up, dn, at_max, at_min, hit_hi, hit_lo;
  logic [WIDTH-1:0] q_next, load_val;
  assign zero = (q == '0);
  // decode the command and boundary events; a load masks counting entirely
  always_comb begin
    up       = ~ld & inc & ~dec;
    dn       = ~ld & dec & ~inc;
    at_max   = (q == MAX_VAL);
    at_min   = (q == '0);
    hit_hi   = up & at_max;
    hit_lo   = dn & at_min;
    load_val = (data_in > MAX_VAL) ? MAX_VAL : data_in;
    q_next   = ld ? load_val :
               up ? (at_max ? (SATURATE ? q : '0) : q + 1'b1) :
               dn ? (at_min ? (SATURATE ? q : MAX_VAL) : q - 1'b1) : q;
  end
  // register count, one-cycle tc pulse and sticky flags (a new event beats clr_flags)
  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      q   <= q_next;
      tc  <= hit_hi | hit_lo;
      ovf <= hit_hi | (ovf & ~clr_flags);
      unf <= hit_lo | (unf & ~clr_flags);
    end
  end
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: scoreboard bench for a wrapping MAX_VAL=9 counter and a saturating 8-bit counter
module tb_param_counter;
  typedef struct {logic [7:0] q; logic tc, ovf, unf, zero;} exp_t;
  typedef struct {bit rst, ld; int din; bit inc, dec, clr; int q; bit tc, ovf, unf;} stim_t;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] a_din = '0, b_din = '0;
  logic       a_ld = 0, a_inc = 0, a_dec = 0, a_clr = 0;
  logic       b_ld = 0, b_inc = 0, b_dec = 0, b_clr = 0;
  logic [7:0] qa, qb;
  logic       tca, ovfa, unfa, zeroa, tcb, ovfb, unfb, zerob;
  int         errors = 0, checks = 0;
  exp_t       sb[$];
  always #5 clk = ~clk;
  param_counter #(.WIDTH(8), .MAX_VAL(8'd9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_din), .ld(a_ld), .inc(a_inc), .dec(a_dec),
    .clr_flags(a_clr), .q(qa), .tc(tca), .ovf(ovfa), .unf(unfa), .zero(zeroa));
  param_counter #(.WIDTH(8), .MAX_VAL(8'd255), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_din), .ld(b_ld), .inc(b_inc), .dec(b_dec),
    .clr_flags(b_clr), .q(qb), .tc(tcb), .ovf(ovfb), .unf(unfb), .zero(zerob));
  function automatic exp_t mk(int q, bit tc, bit ovf, bit unf);
    exp_t e;
    e.q = 8'(q); e.tc = tc; e.ovf = ovf; e.unf = unf; e.zero = (q == 0);
    return e;
  endfunction
  function automatic string fmt(logic [7:0] q, logic tc, logic ovf, logic unf, logic zero);
    return $sformatf("q=%0d tc=%b ovf=%b unf=%b zero=%b", q, tc, ovf, unf, zero);
  endfunction
  task automatic drive_a(stim_t t);
    rst = t.rst; a_ld = t.ld; a_din = 8'(t.din); a_inc = t.inc; a_dec = t.dec; a_clr = t.clr;
  endtask
  task automatic drive_b(stim_t t);
    rst = t.rst; b_ld = t.ld; b_din = 8'(t.din); b_inc = t.inc; b_dec = t.dec; b_clr = t.clr;
  endtask
  task automatic test_reset();
    exp_t e;
    rst = 1; a_inc = 1; b_inc = 1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({qa, tca, ovfa, unfa, zeroa} !== {e.q, e.tc, e.ovf, e.unf, e.zero}) begin
        errors++; $display("FAIL reset_a[%0d]: got %s want %s", i, fmt(qa, tca, ovfa, unfa, zeroa), fmt(e.q, e.tc, e.ovf, e.unf, e.zero));
      end
      e = sb.pop_front(); checks++;
      if ({qb, tcb, ovfb, unfb, zerob} !== {e.q, e.tc, e.ovf, e.unf, e.zero}) begin
        errors++; $display("FAIL reset_b[%0d]: got %s want %s", i, fmt(qb, tcb, ovfb, unfb, zerob), fmt(e.q, e.tc, e.ovf, e.unf, e.zero));
      end
    end
    rst = 0; a_inc = 0; b_inc = 0;
  endtask
  task automatic run_table_a(string name, stim_t t[$]);
    exp_t e;
    foreach (t[i]) begin
      drive_a(t[i]);
      sb.push_back(mk(t[i].q, t[i].tc, t[i].ovf, t[i].unf));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({qa, tca, ovfa, unfa, zeroa} !== {e.q, e.tc, e.ovf, e.unf, e.zero}) begin
        errors++; $display("FAIL %s[%0d]: got %s want %s", name, i, fmt(qa, tca, ovfa, unfa, zeroa), fmt(e.q, e.tc, e.ovf, e.unf, e.zero));
      end
    end
    drive_a('{default: 0});
  endtask
  task automatic test_wrap_up();
    run_table_a("wrap_up", '{
      '{0,1,8,0,0,0, 8,0,0,0},
      '{0,0,0,1,0,0, 9,0,0,0},
      '{0,0,0,1,0,0, 0,1,1,0},
      '{0,0,0,1,0,0, 1,0,1,0}});
  endtask
  task automatic test_wrap_down();
    run_table_a("wrap_down", '{
      '{0,1,1,0,0,0, 1,0,1,0},
      '{0,0,0,0,1,0, 0,0,1,0},
      '{0,0,0,0,1,0, 9,1,1,1},
      '{0,0,0,0,1,0, 8,0,1,1},
      '{0,0,0,0,0,1, 8,0,0,0}});
  endtask
  task automatic test_saturate();
    stim_t t[$] = '{
      '{0,1,254,0,0,0, 254,0,0,0},
      '{0,0,0,1,0,0, 255,0,0,0},
      '{0,0,0,1,0,0, 255,1,1,0},
      '{0,0,0,1,0,0, 255,1,1,0},
      '{0,0,0,0,0,0, 255,0,1,0},
      '{0,1,0,0,0,0, 0,0,1,0},
      '{0,0,0,0,1,0, 0,1,1,1},
      '{0,0,0,0,1,1, 0,1,0,1}};
    exp_t e;
    foreach (t[i]) begin
      drive_b(t[i]);
      sb.push_back(mk(t[i].q, t[i].tc, t[i].ovf, t[i].unf));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({qb, tcb, ovfb, unfb, zerob} !== {e.q, e.tc, e.ovf, e.unf, e.zero}) begin
        errors++; $display("FAIL saturate[%0d]: got %s want %s", i, fmt(qb, tcb, ovfb, unfb, zerob), fmt(e.q, e.tc, e.ovf, e.unf, e.zero));
      end
    end
    drive_b('{default: 0});
  endtask
  task automatic test_priority();
    run_table_a("priority", '{
      '{0,1,200,1,0,0, 9,0,0,0},
      '{0,0,0,1,1,0, 9,0,0,0},
      '{0,0,0,1,0,1, 0,1,1,0},
      '{0,0,0,0,1,1, 9,1,0,1},
      '{0,1,3,1,0,0, 3,0,0,1},
      '{0,0,0,0,0,1, 3,0,0,0}});
  endtask
  task automatic test_reset_mid();
    run_table_a("reset_mid", '{
      '{0,1,4,0,0,0, 4,0,0,0},
      '{0,0,0,1,0,0, 5,0,0,0},
      '{1,0,0,1,0,0, 0,0,0,0},
      '{0,0,0,1,0,0, 1,0,0,0},
      '{0,1,9,0,0,0, 9,0,0,0},
      '{1,1,5,1,0,0, 0,0,0,0},
      '{0,0,0,0,0,0, 0,0,0,0}});
  endtask
  task automatic test_random();
    int  mq = 0;
    bit  mtc = 0, movf = 0, munf = 0, hi, lo;
    exp_t e;
    stim_t s;
    for (int i = 0; i < 300; i++) begin
      s = '{default: 0};
      s.rst = ($urandom_range(0, 39) == 0);
      s.ld  = ($urandom_range(0, 7) == 0);
      s.din = $urandom_range(0, 255);
      s.inc = $urandom_range(0, 1);
      s.dec = $urandom_range(0, 1);
      s.clr = ($urandom_range(0, 7) == 0);
      drive_a(s);
      if (s.rst) begin
        mq = 0; mtc = 0; movf = 0; munf = 0;
      end else begin
        hi = !s.ld && s.inc && !s.dec && mq == 9;
        lo = !s.ld && s.dec && !s.inc && mq == 0;
        if (s.ld) mq = (s.din > 9) ? 9 : s.din;
        else if (s.inc && !s.dec) mq = (mq + 1) % 10;
        else if (s.dec && !s.inc) mq = (mq + 9) % 10;
        mtc = hi || lo;
        movf = hi || (movf && !s.clr);
        munf = lo || (munf && !s.clr);
      end
      sb.push_back(mk(mq, mtc, movf, munf));
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({qa, tca, ovfa, unfa, zeroa} !== {e.q, e.tc, e.ovf, e.unf, e.zero}) begin
        errors++; $display("FAIL random[%0d]: got %s want %s", i, fmt(qa, tca, ovfa, unfa, zeroa), fmt(e.q, e.tc, e.ovf, e.unf, e.zero));
      end
    end
    drive_a('{default: 0});
  endtask
  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
